// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin arbiter that shares the register-file write port among NREQ writeback
//          requesters, plus a 32-entry pending-write scoreboard for the issue stage.
// Latency: the grant is combinational in the request cycle; wb_en/wb_addr/wb_data are registered
//          and appear one cycle after the transfer edge. Throughput is one write per cycle.
// Backpressure: valid/ready per requester; wb_hold or reset forces every req_ready low.
// Ports:
//   clock, reset               rising-edge clock, async active-high reset
//   req_valid/addr/data        packed per-requester write requests (requester i at slice i)
//   req_ready                  one-hot grant
//   wb_hold                    freezes arbitration
//   wb_en/wb_addr/wb_data      registered write port into the 5-to-32 write-select decoder
//   iss_valid/iss_addr         destination register of an issuing instruction (sets pending bit)
//   rs1/rs2_addr, rs1/rs2_busy source-register pending lookup (combinational)
//   busy_vec                   full scoreboard
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [5*NREQ-1:0]      req_addr,
    input  logic [DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   wb_hold,
    output logic                   wb_en,
    output logic [4:0]             wb_addr,
    output logic [DATA_W-1:0]      wb_data,
    input  logic                   iss_valid,
    input  logic [4:0]             iss_addr,
    input  logic [4:0]             rs1_addr,
    input  logic [4:0]             rs2_addr,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic [31:0]            busy_vec
);

    localparam int PTR_W = (NREQ > 2) ? 2 : 1;

    logic [PTR_W-1:0]  rr_q, rr_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [31:0]       busy_q, busy_d;

    logic [PTR_W:0]    scan_sum;
    logic [PTR_W-1:0]  scan_idx;
    logic              found;
    logic [PTR_W-1:0]  win_idx;
    logic              xfer;
    logic [4:0]        win_addr;
    logic [DATA_W-1:0] win_data;

    // Search upward from rr_q with modulo-NREQ wrap; the first valid requester wins.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_q} + (PTR_W+1)'(k);
            scan_idx = (scan_sum >= (PTR_W+1)'(NREQ)) ? PTR_W'(scan_sum - (PTR_W+1)'(NREQ))
                                                      : PTR_W'(scan_sum);
            if (!found && req_valid[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // The winner is valid by construction, so an enabled grant is always a transfer.
    // Reset gates the grant so nothing is consumed while the write port is being cleared.
    assign xfer = found & ~wb_hold & ~reset;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_addr = req_addr[5*i +: 5];
                win_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_d      = rr_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        busy_d    = busy_q;
        if (xfer) begin
            rr_d      = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
            wb_en_d   = (win_addr != 5'd0);
            wb_addr_d = win_addr;
            wb_data_d = win_data;
            if (win_addr != 5'd0) begin
                busy_d[win_addr] = 1'b0;
            end
        end
        // Applied after the clear so an issue to the same register keeps it pending.
        if (iss_valid && (iss_addr != 5'd0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_q      <= rr_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_en    = wb_en_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign busy_vec = busy_q;
    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: each scenario task drives requests, predicts the grant and the
// registered write from a small reference model, queues the expected write, and pops it after
// the transfer edge for comparison.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 32;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_addr;
    logic [DW*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wb_hold;
    logic                 wb_en;
    logic [4:0]           wb_addr;
    logic [DW-1:0]        wb_data;
    logic                 iss_valid;
    logic [4:0]           iss_addr;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic [31:0]          busy_vec;

    regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .wb_hold(wb_hold), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy_vec(busy_vec)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          en;
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wb_t;

    wb_t             exp_q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              m_rr;
    logic [31:0]     m_busy;
    logic [4:0]      m_addr;
    logic [DW-1:0]   m_data;
    logic [NREQ-1:0] rv;
    logic [4:0]      ra[NREQ];
    logic [DW-1:0]   rd[NREQ];
    logic [NREQ-1:0] eg;

    function automatic logic [NREQ-1:0] f_grant(input logic [NREQ-1:0] v, input int rr, input logic hold);
        logic [NREQ-1:0] g;
        int idx;
        g = '0;
        // Walk the search order backwards so the earliest valid requester is assigned last.
        if (!hold) begin
            for (int k = NREQ-1; k >= 0; k--) begin
                idx = (rr + k) % NREQ;
                if (v[idx]) g = NREQ'(1) << idx;
            end
        end
        return g;
    endfunction

    task automatic drive();
        req_valid = rv;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[5*i +: 5]  = ra[i];
            req_data[DW*i +: DW] = rd[i];
        end
    endtask

    task automatic model_reset();
        m_rr   = 0;
        m_busy = '0;
        m_addr = '0;
        m_data = '0;
        exp_q.delete();
    endtask

    // Predicts the grant for the current inputs, queues the write expected after the edge,
    // and advances the model state across that edge.
    task automatic predict();
        wb_t e;
        int  w;
        eg     = f_grant(req_valid, m_rr, wb_hold);
        e.en   = 1'b0;
        e.addr = m_addr;
        e.data = m_data;
        if (eg != '0) begin
            w = 0;
            for (int i = 0; i < NREQ; i++) if (eg[i]) w = i;
            m_addr = ra[w];
            m_data = rd[w];
            e.en   = (m_addr != 5'd0);
            e.addr = m_addr;
            e.data = m_data;
            if (m_addr != 5'd0) m_busy[m_addr] = 1'b0;
            m_rr = (w + 1) % NREQ;
        end
        if (iss_valid && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rv = '1;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 5'(i + 1);
            rd[i] = 32'hFFFF_0000;
        end
        drive();
        tick();
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
        n_cmp++; if (wb_addr !== 5'd0) begin n_err++; $display("FAIL reset_wb_addr: got %0d want 0", wb_addr); end
        n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
        n_cmp++; if (busy_vec !== 32'd0) begin n_err++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
        n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        rv = '0;
        drive();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_midop();
        wb_t e;
        rv = 3'b001; ra[0] = 5'd3; rd[0] = 32'h3333_0003;
        iss_valid = 1'b1; iss_addr = 5'd8;
        drive();
        #4; predict(); tick();
        rv = '0; iss_valid = 1'b0; drive();
        e = exp_q.pop_front();
        n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data}) begin n_err++;
            $display("FAIL midop_pre wb: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", wb_en, wb_addr, wb_data, e.en, e.addr, e.data); end
        n_cmp++; if (busy_vec !== 32'h0000_0100) begin n_err++; $display("FAIL midop_pre busy: got %h want 00000100", busy_vec); end
        rv = '1; drive();
        #2; reset = 1'b1; #1;
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL midop_wb_en: got %b want 0", wb_en); end
        n_cmp++; if (wb_addr !== 5'd0) begin n_err++; $display("FAIL midop_wb_addr: got %0d want 0", wb_addr); end
        n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL midop_wb_data: got %h want 0", wb_data); end
        n_cmp++; if (busy_vec !== 32'd0) begin n_err++; $display("FAIL midop_busy: got %h want 0", busy_vec); end
        n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL midop_ready: got %b want 000", req_ready); end
        tick();
        rv = '0; drive();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        wb_t e;
        logic [NREQ-1:0] pat[3];
        logic [NREQ-1:0] want[3];
        pat  = '{3'b101, 3'b001, 3'b100};
        want = '{3'b100, 3'b001, 3'b100};
        iss_valid = 1'b1; iss_addr = 5'd7; rs1_addr = 5'd7; rv = '0; drive();
        #4; predict(); tick();
        iss_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data}) begin n_err++;
            $display("FAIL single_iss wb: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", wb_en, wb_addr, wb_data, e.en, e.addr, e.data); end
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL single_rs1_set: got %b want 1", rs1_busy); end
        rv = 3'b010; ra[1] = 5'd7; rd[1] = 32'hDEAD_BEEF; drive();
        #4;
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL single_grant: got %b want 010", req_ready); end
        predict(); tick();
        rv = '0; drive();
        e = exp_q.pop_front();
        n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data}) begin n_err++;
            $display("FAIL single_wb: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", wb_en, wb_addr, wb_data, e.en, e.addr, e.data); end
        n_cmp++; if (busy_vec[7] !== 1'b0 || rs1_busy !== 1'b0) begin n_err++;
            $display("FAIL single_clear: got busy7=%b rs1_busy=%b want 0 0", busy_vec[7], rs1_busy); end
        // Pointer sits at 2: {0,2} valid must pick 2, then 0, then 2 leaves it back at 0.
        for (int c = 0; c < 3; c++) begin
            rv = pat[c];
            for (int i = 0; i < NREQ; i++) begin
                ra[i] = 5'(16 + i);
                rd[i] = 32'hC000_0000 + 32'(i);
            end
            drive();
            #4;
            n_cmp++; if (req_ready !== want[c]) begin n_err++; $display("FAIL single_rr%0d: got %b want %b", c, req_ready, want[c]); end
            predict(); tick();
            rv = '0; drive();
            e = exp_q.pop_front();
            n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data}) begin n_err++;
                $display("FAIL single_rr%0d wb: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", c, wb_en, wb_addr, wb_data, e.en, e.addr, e.data); end
        end
    endtask

    task automatic test_fairness();
        wb_t e;
        rv = '1;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 5'(10 + i);
            rd[i] = 32'hA000_0000 + 32'(i);
        end
        for (int c = 0; c < 6; c++) begin
            drive();
            #4;
            n_cmp++; if (req_ready !== NREQ'(1 << (c % 3))) begin n_err++;
                $display("FAIL fair_grant%0d: got %b want %b", c, req_ready, NREQ'(1 << (c % 3))); end
            predict(); tick();
            for (int i = 0; i < NREQ; i++) begin
                if (eg[i]) begin
                    rd[i] = rd[i] + 32'h100;
                    if (c >= 3) rv[i] = 1'b0;
                end
            end
            drive();
            e = exp_q.pop_front();
            n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data} || wb_en !== 1'b1) begin n_err++;
                $display("FAIL fair_wb%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h", c, wb_en, wb_addr, wb_data, e.addr, e.data); end
        end
    endtask

    task automatic test_reg0();
        wb_t e;
        iss_valid = 1'b1; iss_addr = 5'd3; drive();
        #4; predict(); tick();
        iss_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data}) begin n_err++;
            $display("FAIL reg0_iss wb: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", wb_en, wb_addr, wb_data, e.en, e.addr, e.data); end
        rv = 3'b001; ra[0] = 5'd0; rd[0] = 32'h0000_1234; rs1_addr = 5'd0; drive();
        #4;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL reg0_grant: got %b want 001", req_ready); end
        predict(); tick();
        rv = '0; drive();
        e = exp_q.pop_front();
        n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data} || wb_en !== 1'b0) begin n_err++;
            $display("FAIL reg0_wb: got en=%b addr=%0d data=%h want en=0 addr=%0d data=%h", wb_en, wb_addr, wb_data, e.addr, e.data); end
        n_cmp++; if (busy_vec !== m_busy || busy_vec[3] !== 1'b1) begin n_err++;
            $display("FAIL reg0_busy: got %h want %h", busy_vec, m_busy); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL reg0_rs1: got %b want 0", rs1_busy); end
    endtask

    task automatic test_collision();
        wb_t e;
        iss_valid = 1'b1; iss_addr = 5'd5; rs2_addr = 5'd5; drive();
        #4; predict(); tick();
        iss_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL coll_set: got rs2_busy=%b want 1", rs2_busy); end
        rv = 3'b010; ra[1] = 5'd5; rd[1] = 32'h5555_5555; iss_valid = 1'b1; iss_addr = 5'd5; drive();
        #4;
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL coll_grant: got %b want 010", req_ready); end
        predict(); tick();
        iss_valid = 1'b0; rv = '0; drive();
        e = exp_q.pop_front();
        n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data}) begin n_err++;
            $display("FAIL coll_wb: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", wb_en, wb_addr, wb_data, e.en, e.addr, e.data); end
        n_cmp++; if (busy_vec[5] !== 1'b1 || busy_vec !== m_busy) begin n_err++;
            $display("FAIL coll_setwins: got busy=%h want %h", busy_vec, m_busy); end
        rv = 3'b010; rd[1] = 32'h6666_6666; drive();
        #4; predict(); tick();
        rv = '0; drive();
        e = exp_q.pop_front();
        n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data}) begin n_err++;
            $display("FAIL coll_wb2: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", wb_en, wb_addr, wb_data, e.en, e.addr, e.data); end
        n_cmp++; if (busy_vec[5] !== 1'b0 || rs2_busy !== 1'b0) begin n_err++;
            $display("FAIL coll_clear: got busy5=%b rs2_busy=%b want 0 0", busy_vec[5], rs2_busy); end
    endtask

    task automatic test_hold();
        wb_t e;
        int  rr0;
        rr0 = m_rr;
        rv = '1;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 5'(20 + i);
            rd[i] = 32'hB000_0000 + 32'(i);
        end
        wb_hold = 1'b1;
        drive();
        for (int c = 0; c < 2; c++) begin
            #4;
            n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL hold_ready%0d: got %b want 000", c, req_ready); end
            predict(); tick();
            e = exp_q.pop_front();
            n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data} || wb_en !== 1'b0) begin n_err++;
                $display("FAIL hold_wb%0d: got en=%b addr=%0d data=%h want en=0 addr=%0d data=%h", c, wb_en, wb_addr, wb_data, e.addr, e.data); end
        end
        wb_hold = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (rv == '0) break;
            drive();
            #4;
            if (c == 0) begin
                n_cmp++; if (req_ready !== NREQ'(1 << rr0)) begin n_err++;
                    $display("FAIL hold_release: got %b want %b", req_ready, NREQ'(1 << rr0)); end
            end else begin
                n_cmp++; if (req_ready !== f_grant(rv, m_rr, 1'b0)) begin n_err++;
                    $display("FAIL hold_drain%0d: got %b want %b", c, req_ready, f_grant(rv, m_rr, 1'b0)); end
            end
            predict(); tick();
            rv = rv & ~eg;
            drive();
            e = exp_q.pop_front();
            n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data}) begin n_err++;
                $display("FAIL hold_wb_after%0d: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", c, wb_en, wb_addr, wb_data, e.en, e.addr, e.data); end
        end
    endtask

    task automatic test_random();
        wb_t e;
        for (int c = 0; c < 90; c++) begin
            if (c < 80) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!rv[i] && ($urandom % 2 == 0)) begin
                        rv[i] = 1'b1;
                        ra[i] = 5'($urandom_range(0, 31));
                        rd[i] = $urandom;
                    end
                end
                wb_hold   = ($urandom % 5 == 0);
                iss_valid = ($urandom % 2 == 0);
                iss_addr  = 5'($urandom_range(0, 31));
            end else begin
                wb_hold   = 1'b0;
                iss_valid = 1'b0;
            end
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            drive();
            #4;
            n_cmp++; if (req_ready !== f_grant(rv, m_rr, wb_hold)) begin n_err++;
                $display("FAIL rand_grant%0d: got %b want %b", c, req_ready, f_grant(rv, m_rr, wb_hold)); end
            n_cmp++; if (rs1_busy !== m_busy[rs1_addr] || rs2_busy !== m_busy[rs2_addr]) begin n_err++;
                $display("FAIL rand_rs%0d: got %b%b want %b%b", c, rs1_busy, rs2_busy, m_busy[rs1_addr], m_busy[rs2_addr]); end
            predict(); tick();
            rv = rv & ~eg;
            e = exp_q.pop_front();
            n_cmp++; if ({wb_en, wb_addr, wb_data} !== {e.en, e.addr, e.data}) begin n_err++;
                $display("FAIL rand_wb%0d: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", c, wb_en, wb_addr, wb_data, e.en, e.addr, e.data); end
            n_cmp++; if (busy_vec !== m_busy) begin n_err++;
                $display("FAIL rand_busy%0d: got %h want %h", c, busy_vec, m_busy); end
        end
        n_cmp++; if (rv !== '0) begin n_err++; $display("FAIL rand_drain: requests left %b want 000", rv); end
        rv = '0;
        drive();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        wb_hold   = 1'b0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        rs1_addr  = '0;
        rs2_addr  = '0;
        rv        = '0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        eg = '0;
        drive();
        model_reset();
        test_reset();
        test_reset_midop();
        test_single();
        test_fairness();
        test_reg0();
        test_collision();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port, driven by the 5-to-32 write-select decoder, among several writeback requesters (ALU, mult/div, load). The block arbitrates round-robin with a valid/ready handshake and registers the winning write into the port, one write per cycle. It also keeps a 32-entry pending-write scoreboard for the issue stage.

## Interface
Parameters:
- NREQ, 3, number of writeback requesters; legal range 2..4.
- DATA_W, 32, write data width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_addr  in  5*NREQ  destination register; requester i uses bits [5i+4:5i].
- req_data  in  DATA_W*NREQ  write data; requester i uses bits [DATA_W*i+DATA_W-1:DATA_W*i].
- req_ready  out  NREQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i] at a clock edge.
- wb_hold  in  1  freezes arbitration, for example during a debug access to the register file.
- wb_en  out  1  write enable to the register file; gates the decoder output.
- wb_addr  out  5  register index into the write-select decoder.
- wb_data  out  DATA_W  write data.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_addr  in  5  destination register of the issuing instruction.
- rs1_addr, rs2_addr  in  5 each  source registers to check.
- rs1_busy, rs2_busy  out  1 each  the source register has an outstanding write.
- busy_vec  out  32  full scoreboard.

## Operation
Arbitration:
- Arbitration is combinational from req_valid, rr_ptr (range 0..NREQ-1) and wb_hold.
- The grant goes to the first valid requester at or after rr_ptr, searching upward with modulo-NREQ wrap.
- req_ready is all-zero when no requester is valid, when wb_hold=1, or while reset is asserted.
- On each transfer, rr_ptr becomes (granted index + 1) mod NREQ. Otherwise rr_ptr holds.

Requester obligations:
- A requester keeps valid, addr and data stable until it is granted.
- A requester does not deassert valid before it is granted.

Write port:
- The transfer edge loads wb_addr and wb_data from the winner.
- wb_en is 1 for exactly the following cycle, unless the winner's address is 0.
- An address-0 request is still granted and consumed. It produces wb_en=0 and leaves the scoreboard unchanged (r0 is hardwired).
- In a cycle with no transfer, wb_en=0 and wb_addr/wb_data hold their last values.

Scoreboard:
- iss_valid with iss_addr≠0 sets busy_vec[iss_addr] at the clock edge.
- A transfer with addr≠0 clears busy_vec[addr] on the transfer edge.
- If a set and a clear target the same index in one cycle, the set wins.
- Setting an already-busy bit leaves it 1; there is no counting. Upstream allows at most one outstanding write per register.
- busy_vec[0] is always 0.
- rs1_busy = busy_vec[rs1_addr] and rs2_busy = busy_vec[rs2_addr], both combinational. A source address of 0 therefore always reads 0.

## Timing
Reset:
- While reset=1, wb_en, wb_addr, wb_data, busy_vec and rr_ptr are 0, and req_ready is 0.
- Asserting reset mid-operation discards any registered write (wb_en drops to 0 immediately) and clears the scoreboard.

Latency:
- The grant is visible in the same cycle as the request.
- Register-file write enable is asserted one cycle after the transfer edge.
- Throughput is one write per cycle, sustained.
- A scoreboard set or clear is visible on busy_vec and rsN_busy in the cycle after the edge.

Hold:
- wb_hold=1 in cycle t means no transfer at the end of t and wb_en=0 in t+1.
- rr_ptr and busy_vec continue to respond to issue traffic only.

## Test plan
- Reset: assert reset asynchronously mid-cycle with wb_en=1 and busy_vec=0x0000_0100 → wb_en, wb_addr, wb_data and busy_vec read 0 immediately, and req_ready=0.
- Single requester: req_valid=3'b010, addr=5'd7, data=0xDEADBEEF → req_ready=3'b010 the same cycle. Next cycle wb_en=1, wb_addr=7, wb_data=0xDEADBEEF, busy_vec[7]=0. rr_ptr=2.
- Round-robin fairness: all three requesters held valid for 6 cycles starting at rr_ptr=0 → grant order 0,1,2,0,1,2, with wb_en=1 on all 6 following cycles.
- Register 0: requester 0 writes addr=0, data=0x1234 → granted, but next cycle wb_en=0. busy_vec stays unchanged and rs1_busy=0 with rs1_addr=0.
- Scoreboard collision: busy_vec[5]=1, then a writeback to r5 and iss_valid with iss_addr=5 in the same cycle → busy_vec[5]=1 after the edge and wb_en=1 for r5. A later writeback to r5 alone clears the bit, so rs2_busy=0 with rs2_addr=5.
- Hold: all requesters valid, wb_hold=1 for 2 cycles → req_ready=0 and wb_en=0 throughout, rr_ptr unchanged. After hold is released, the first grant goes to the prior rr_ptr index.
